// File: rtl/tuart_pkg.sv
// Shared types and helpers for the tuart transmitter and FIFO.
// Frame format and state encoding live here so benches and a future receiver agree.
package tuart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tuart_tx_state_t;

    typedef enum logic [1:0] {
        PAR_NONE = 2'b00,
        PAR_EVEN = 2'b01,
        PAR_ODD  = 2'b10
    } tuart_parity_t;

    // Total serial bits in one frame: start + data + optional parity + stop(s).
    function automatic int frame_bits(input int data_w, input logic stop2, input logic par_en);
        return 1 + data_w + (par_en ? 1 : 0) + (stop2 ? 2 : 1);
    endfunction

endpackage

// File: rtl/tuart_fifo.sv
// Synchronous FIFO with extra-MSB pointers; shared by the UART transmit path and a future receiver.
// Pushes while full and pops while empty are ignored.
module tuart_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = $clog2(DEPTH + 1)
) (
    input  logic              clk_i,
    input  logic              rst_in,
    input  logic              push_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] data_o,
    output logic              full_o,
    output logic              empty_o,
    output logic [LW-1:0]     level_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW:0]       wptr_q, wptr_d;
    logic [AW:0]       rptr_q, rptr_d;
    logic [LW-1:0]     level_q, level_d;
    logic              push_ok, pop_ok;

    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign empty_o = (wptr_q == rptr_q);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign data_o  = mem_q[rptr_q[AW-1:0]];
    assign level_o = level_q;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        if (push_ok) wptr_d = wptr_q + 1'b1;
        if (pop_ok)  rptr_d = rptr_q + 1'b1;
        case ({push_ok, pop_ok})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_in) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
        end
    end

    // Storage needs no reset; only the pointers define validity.
    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wptr_q[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/tuart_tx_fifo.sv
// UART transmitter fed by a tuart_fifo; frames stream back-to-back while words are queued.
// Optional parity bit is built only when TUART_TX_PARITY_EN is defined.
module tuart_tx_fifo
    import tuart_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    parameter int DIV_W  = 16,
    localparam int LW    = $clog2(DEPTH + 1)
) (
    input  logic              clk_i,
    input  logic              rst_in,
    input  logic [DIV_W-1:0]  cycles_per_bit_i,
    input  logic              stop2_i,
`ifdef TUART_TX_PARITY_EN
    input  logic [1:0]        parity_i,
`endif
    input  logic [DATA_W-1:0] data_i,
    input  logic              valid_i,
    output logic              ready_o,
    output logic              tx_o,
    output logic              busy_o,
    output logic [LW-1:0]     level_o
);

    localparam int BCW = $clog2(DATA_W);

    tuart_tx_state_t   state_q, state_d;
    logic [DIV_W-1:0]  cnt_q, cnt_d;
    logic [DIV_W-1:0]  rl_q, rl_d;
    logic              stop2_q, stop2_d;
    logic              stop_n_q, stop_n_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [BCW-1:0]    bitcnt_q, bitcnt_d;
    logic              tx_q, tx_d;
    logic              busy_q, busy_d;
`ifdef TUART_TX_PARITY_EN
    logic              par_en_q, par_en_d;
    logic              par_bit_q, par_bit_d;
`endif

    logic              fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic [DATA_W-1:0] fifo_dout;
    logic [DIV_W-1:0]  div_m1;
    logic [LW-1:0]     nxt_lvl;
    logic              bit_end;

    assign ready_o   = !fifo_full;
    assign fifo_push = valid_i && !fifo_full;
    assign tx_o      = tx_q;
    assign busy_o    = busy_q;
    assign bit_end   = (cnt_q == '0);
    assign div_m1    = (cycles_per_bit_i == '0) ? '0 : cycles_per_bit_i - 1'b1;

    tuart_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
        .clk_i   (clk_i),
        .rst_in  (rst_in),
        .push_i  (fifo_push),
        .data_i  (data_i),
        .pop_i   (fifo_pop),
        .data_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (level_o)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rl_d     = rl_q;
        stop2_d  = stop2_q;
        stop_n_d = stop_n_q;
        shreg_d  = shreg_q;
        bitcnt_d = bitcnt_q;
        tx_d     = tx_q;
        fifo_pop = 1'b0;
`ifdef TUART_TX_PARITY_EN
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;
`endif
        if (state_q != ST_IDLE && !bit_end) cnt_d = cnt_q - 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) fifo_pop = 1'b1;
            end
            ST_START: begin
                if (bit_end) begin
                    state_d  = ST_DATA;
                    tx_d     = shreg_q[0];
                    shreg_d  = shreg_q >> 1;
                    bitcnt_d = '0;
                    cnt_d    = rl_q;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    cnt_d = rl_q;
                    if (bitcnt_q == BCW'(DATA_W - 1)) begin
                        state_d = ST_STOP;
                        tx_d    = 1'b1;
`ifdef TUART_TX_PARITY_EN
                        if (par_en_q) begin
                            state_d = ST_PARITY;
                            tx_d    = par_bit_q;
                        end
`endif
                    end else begin
                        tx_d     = shreg_q[0];
                        shreg_d  = shreg_q >> 1;
                        bitcnt_d = bitcnt_q + 1'b1;
                    end
                end
            end
`ifdef TUART_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_end) begin
                    state_d = ST_STOP;
                    tx_d    = 1'b1;
                    cnt_d   = rl_q;
                end
            end
`endif
            ST_STOP: begin
                if (bit_end) begin
                    if (stop2_q && !stop_n_q) begin
                        stop_n_d = 1'b1;
                        cnt_d    = rl_q;
                    end else if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Frame launch: config is captured here and held for the whole frame.
        if (fifo_pop) begin
            state_d  = ST_START;
            tx_d     = 1'b0;
            shreg_d  = fifo_dout;
            rl_d     = div_m1;
            cnt_d    = div_m1;
            stop2_d  = stop2_i;
            stop_n_d = 1'b0;
`ifdef TUART_TX_PARITY_EN
            par_en_d  = (parity_i == PAR_EVEN) || (parity_i == PAR_ODD);
            par_bit_d = (^fifo_dout) ^ (parity_i == PAR_ODD);
`endif
        end

        nxt_lvl = level_o + LW'(fifo_push) - LW'(fifo_pop);
        busy_d  = (state_d != ST_IDLE) || (nxt_lvl != '0);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_in) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            rl_q     <= '0;
            stop2_q  <= 1'b0;
            stop_n_q <= 1'b0;
            shreg_q  <= '0;
            bitcnt_q <= '0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
`ifdef TUART_TX_PARITY_EN
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rl_q     <= rl_d;
            stop2_q  <= stop2_d;
            stop_n_q <= stop_n_d;
            shreg_q  <= shreg_d;
            bitcnt_q <= bitcnt_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
`ifdef TUART_TX_PARITY_EN
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
`endif
        end
    end

endmodule

// File: tb/tb_tuart_tx_fifo.sv
// Directed bench for tuart_tx_fifo: frame timing, streaming, FIFO full, reset abort, divider edges.
// Parity vectors are included when TUART_TX_PARITY_EN is defined.
module tb_tuart_tx_fifo;
    import tuart_pkg::*;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 8;
    localparam int DIV_W  = 16;
    localparam int LW     = $clog2(DEPTH + 1);

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [DIV_W-1:0]  cyc = 16'd4;
    logic              stop2 = 1'b0;
    logic [1:0]        parity = 2'b00;
    logic [DATA_W-1:0] data = '0;
    logic              valid = 1'b0;
    logic              ready, tx, busy;
    logic [LW-1:0]     level;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    tuart_tx_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .DIV_W(DIV_W)) dut (
        .clk_i            (clk),
        .rst_in           (rst_n),
        .cycles_per_bit_i (cyc),
        .stop2_i          (stop2),
`ifdef TUART_TX_PARITY_EN
        .parity_i         (parity),
`endif
        .data_i           (data),
        .valid_i          (valid),
        .ready_o          (ready),
        .tx_o             (tx),
        .busy_o           (busy),
        .level_o          (level)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called #1 after the edge that launches the start bit; returns #1 after the frame-end edge.
    // par < 0 means no parity bit, otherwise par[0] is the expected parity bit.
    task automatic expect_frame(input logic [DATA_W-1:0] d, input int div, input logic s2, input int par);
        int de, n;
        logic [15:0] eb;
        logic [DATA_W-1:0] rx;
        de = (div == 0) ? 1 : div;
        n  = frame_bits(DATA_W, s2, par >= 0);
        eb = '1;
        eb[0] = 1'b0;
        for (int i = 0; i < DATA_W; i++) eb[1+i] = d[i];
        if (par >= 0) eb[1+DATA_W] = par[0];
        rx = '0;
        for (int b = 0; b < n; b++) begin
            for (int j = 0; j < de; j++) begin
                if (j == 0 && b >= 1 && b <= DATA_W) rx[b-1] = tx;
                chk($sformatf("tx word %0h bit %0d clk %0d", d, b, j), {31'd0, tx}, {31'd0, eb[b]});
                step();
            end
        end
        chk($sformatf("decoded word %0h", d), {24'd0, rx}, {24'd0, d});
    endtask

    task automatic send_one(input logic [DATA_W-1:0] d, input int div, input logic s2, input int par);
        cyc   = DIV_W'(div);
        stop2 = s2;
        data  = d;
        valid = 1'b1;
        step();
        valid = 1'b0;
        chk("tx idle at push edge", {31'd0, tx}, 32'd1);
        chk("busy after push", {31'd0, busy}, 32'd1);
        chk("level after push", {28'd0, level}, 32'd1);
        step();
        chk("level after pop", {28'd0, level}, 32'd0);
        expect_frame(d, div, s2, par);
        chk("busy after frame", {31'd0, busy}, 32'd0);
        chk("tx idle after frame", {31'd0, tx}, 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        step();
        step();
        chk("reset tx", {31'd0, tx}, 32'd1);
        chk("reset ready", {31'd0, ready}, 32'd1);
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset level", {28'd0, level}, 32'd0);
        rst_n = 1'b1;
        step();

        // Single frame 0x55, div 4, one stop: 40 clocks then idle
        send_one(8'h55, 4, 1'b0, -1);

        // Three back-to-back frames, div 2, two stops
        cyc   = 16'd2;
        stop2 = 1'b1;
        fork
            begin
                data = 8'hA3; valid = 1'b1; step();
                data = 8'h0F; step();
                data = 8'hFF; step();
                valid = 1'b0;
            end
            begin
                step();
                step();
                expect_frame(8'hA3, 2, 1'b1, -1);
                expect_frame(8'h0F, 2, 1'b1, -1);
                expect_frame(8'hFF, 2, 1'b1, -1);
            end
        join
        chk("busy after stream", {31'd0, busy}, 32'd0);
        stop2 = 1'b0;

`ifdef TUART_TX_PARITY_EN
        parity = 2'b01;
        send_one(8'h07, 4, 1'b0, 1);
        parity = 2'b10;
        send_one(8'h07, 4, 1'b0, 0);
        parity = 2'b11;
        send_one(8'h07, 3, 1'b0, -1);
        parity = 2'b00;
`endif

        // Divider 0 and 1 both give one clock per bit
        send_one(8'h96, 0, 1'b0, -1);
        send_one(8'h3C, 1, 1'b0, -1);

        // Divider change mid-frame only affects the next frame
        cyc = 16'd4;
        fork
            begin
                data = 8'h5A; valid = 1'b1; step();
                data = 8'hC3; step();
                valid = 1'b0;
                step();
                step();
                cyc = 16'd8;
            end
            begin
                step();
                step();
                expect_frame(8'h5A, 4, 1'b0, -1);
                expect_frame(8'hC3, 8, 1'b0, -1);
            end
        join
        chk("busy after div change", {31'd0, busy}, 32'd0);

        // Fill the FIFO with valid held high
        cyc   = 16'd16;
        valid = 1'b1;
        for (int k = 0; k <= 8; k++) begin
            data = DATA_W'(k);
            step();
            chk($sformatf("fill level k=%0d", k), {28'd0, level}, (k <= 1) ? 32'd1 : 32'(k));
            chk($sformatf("fill ready k=%0d", k), {31'd0, ready}, (k == 8) ? 32'd0 : 32'd1);
        end
        data = 8'hEE;
        step();
        chk("push refused when full", {28'd0, level}, 32'd8);
        valid = 1'b0;
        #1;
        chk("ready independent of valid", {31'd0, ready}, 32'd0);
        rst_n = 1'b0;
        step();
        chk("reset clears full level", {28'd0, level}, 32'd0);
        chk("reset clears full ready", {31'd0, ready}, 32'd1);
        rst_n = 1'b1;
        step();

        // Reset during DATA with three words queued
        cyc   = 16'd4;
        data  = 8'h10; valid = 1'b1; step();
        data  = 8'h22; step();
        data  = 8'h33; step();
        data  = 8'h44; step();
        valid = 1'b0;
        chk("queued before abort", {28'd0, level}, 32'd3);
        step(); step(); step(); step();
        chk("data bit0 before abort", {31'd0, tx}, 32'd0);
        rst_n = 1'b0;
        step();
        chk("abort tx", {31'd0, tx}, 32'd1);
        chk("abort level", {28'd0, level}, 32'd0);
        chk("abort busy", {31'd0, busy}, 32'd0);
        chk("abort ready", {31'd0, ready}, 32'd1);
        rst_n = 1'b1;
        for (int i = 0; i < 60; i++) begin
            step();
            chk($sformatf("post-abort tx cyc %0d", i), {31'd0, tx}, 32'd1);
            chk($sformatf("post-abort busy cyc %0d", i), {31'd0, busy}, 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
